cu_sequencer: RTL and testbench
===============================

# cu_sequencer

Multi-cycle control sequencer for the CS147DV processor datapath. It steps every instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and latches the instruction word. It drives the register file's read/write strobes and 5-bit addresses, the memory strobes, the ALU operation code and PC update control. It sits directly upstream of the 32x32 register file and supplies every control input the register file consumes.

## Interface
Parameters:
- `DATA_WIDTH`, 32: instruction/data word width.
- `ADDR_BITS`, 5: register address width.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `RST`, in, 1: reset, asynchronous and active-high.
- `MEM_DATA`, in, 32: instruction word returned by memory during FETCH (valid same cycle).
- `ZERO`, in, 1: ALU zero flag.
- `RF_READ`, out, 1: register file read enable.
- `RF_WRITE`, out, 1: register file write enable.
- `RF_ADDR_R1`, out, 5: register file read port 1 address (rs).
- `RF_ADDR_R2`, out, 5: register file read port 2 address (rt).
- `RF_ADDR_W`, out, 5: register file write address.
- `MEM_READ`, out, 1: memory read strobe.
- `MEM_WRITE`, out, 1: memory write strobe.
- `ALU_OPRN`, out, 6: ALU operation code.
- `WB_SEL`, out, 2: write-data select: 0 ALU, 1 memory, 2 PC+1.
- `PC_LOAD`, out, 1: PC update strobe.
- `PC_SEL`, out, 2: next-PC source: 0 PC+1, 1 branch target, 2 jump target, 3 rs (jr).
- `STATE`, out, 3: current state encoding.
- `ILLEGAL`, out, 1: sticky flag for an undefined opcode.

## Operation
- State encodings: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
- Transitions: FETCH→DECODE→EXE→MEM→WB→FETCH unconditionally. Every instruction takes exactly 5 cycles.
- FETCH:
  - `MEM_READ`=1.
  - IR ← `MEM_DATA` on the edge leaving FETCH.
- DECODE and EXE: `RF_READ`=1. `RF_ADDR_R1`=IR[25:21] and `RF_ADDR_R2`=IR[20:16] are held from DECODE through WB.
- EXE:
  - `ALU_OPRN` is valid.
  - The branch flag is captured on the edge leaving EXE: taken = (beq & `ZERO`) | (bne & !`ZERO`).
- MEM:
  - lw: `MEM_READ`=1.
  - sw: `MEM_WRITE`=1.
  - All other instructions: both strobes 0.
- WB:
  - `PC_LOAD`=1 for every instruction.
  - `RF_WRITE`=1 only for R-type (except jr), addi, lw and jal.
  - `RF_ADDR_W` = rd (IR[15:11]) for R-type, rt for addi/lw, 31 for jal.
- Opcode decoding:
  - R-type (op 0x00): `ALU_OPRN` = funct; funct 0x08 = jr, which sets `PC_SEL`=3 and no write.
  - addi 0x08, lw 0x23, sw 0x2B: `ALU_OPRN`=ADD.
  - beq 0x04, bne 0x05: `ALU_OPRN`=SUB; `PC_SEL`=1 if the branch flag is set, else 0.
  - j 0x02: `PC_SEL`=2.
  - jal 0x03: `PC_SEL`=2, `WB_SEL`=2, write to r31.
  - Any other opcode: executes as a NOP (no RF/memory write, `PC_SEL`=0) and sets `ILLEGAL`, which is cleared only by reset.
- Outputs not named active in a state are 0. Addresses outside their valid states are don't-care but must be stable (driven from IR).

## Timing
- While `RST`=1:
  - State = FETCH, IR = 0, branch flag = 0, `ILLEGAL` = 0.
  - Every output is forced to 0, including `STATE`.
- Reset release: the first cycle after `RST` falls is FETCH, with `MEM_READ`=1 combinationally in that cycle.
- Reset asserted mid-instruction: the instruction is abandoned immediately. No `RF_WRITE`, `MEM_WRITE` or `PC_LOAD` is issued in the cycle `RST` rises.
- Control outputs are combinational from state and IR. The register file samples `RF_WRITE`/`RF_ADDR_W` on the rising edge that ends WB.
- A write in WB is visible on the next instruction's DECODE read. No forwarding or stall logic is needed.

## Structure
- Shared package `proc_ctrl_pkg` holds:
  - state encodings;
  - opcode and funct constants;
  - ALU codes (ADD=6'h20, SUB=6'h22, matching R-type funct);
  - `PC_SEL`/`WB_SEL` codes.
- Sub-module `cu_decode`: purely combinational IR → {`ALU_OPRN`, write-enable class, `RF_ADDR_W`, `WB_SEL`, jump/branch type, illegal}.
- The sequencer holds the state register, IR, branch flag and `ILLEGAL` flop.

## Test plan
- Reset then IR=add r3,r1,r2 (0x00221820):
  - `STATE` cycles 0,1,2,3,4.
  - `RF_ADDR_R1`=1, `RF_ADDR_R2`=2.
  - `ALU_OPRN`=0x20.
  - WB: `RF_WRITE`=1, `RF_ADDR_W`=3, `PC_SEL`=0.
- lw r5,4(r1) (0x8C250004): MEM `MEM_READ`=1; WB `RF_WRITE`=1, `RF_ADDR_W`=5, `WB_SEL`=1. sw (0xAC250004): MEM `MEM_WRITE`=1; WB `RF_WRITE`=0.
- beq r1,r2 (0x10220003): `ZERO`=1 in EXE gives WB `PC_SEL`=1; `ZERO`=0 gives `PC_SEL`=0; `RF_WRITE`=0 in both cases.
- jal (0x0C000010): WB `RF_ADDR_W`=31, `WB_SEL`=2, `PC_SEL`=2, `RF_WRITE`=1. jr r31 (0x03E00008): `PC_SEL`=3, `RF_WRITE`=0.
- Opcode 0x3F:
  - `ILLEGAL` rises and stays high across the following add.
  - `RST` pulse clears it.
- `RST` asserted asynchronously in MEM of a sw:
  - `MEM_WRITE` drops immediately; no `PC_LOAD`.
  - After release, `STATE`=0 and `MEM_READ`=1.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared control encodings for the CS147DV datapath: states, opcodes, ALU codes, mux selects.
// Constants only; no timing.
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Control-flow class of the latched instruction
    typedef enum logic [2:0] {
        FLOW_SEQ  = 3'd0,
        FLOW_BEQ  = 3'd1,
        FLOW_BNE  = 3'd2,
        FLOW_JUMP = 3'd3,
        FLOW_JR   = 3'd4
    } flow_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    // ALU codes share the R-type funct numbering
    localparam logic [5:0] ALU_NOP  = 6'h00;
    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_SUB  = 6'h22;

    localparam logic [1:0] PC_SEL_INC    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
    localparam logic [1:0] PC_SEL_RS     = 2'd3;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC1 = 2'd2;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/cu_decode.sv
// Instruction decoder: IR -> ALU op, writeback class/address, memory class, flow type, illegal.
// Purely combinational, zero latency.
module cu_decode
    import proc_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 5
) (
    input  logic [31:0]          i_ir,
    output logic [5:0]           o_alu_oprn,
    output logic                 o_rf_wr,
    output logic [ADDR_BITS-1:0] o_rf_addr_w,
    output logic [1:0]           o_wb_sel,
    output logic                 o_mem_rd,
    output logic                 o_mem_wr,
    output flow_t                o_flow,
    output logic                 o_illegal
);

    logic [5:0] w_op;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [5:0] w_funct;
    logic       w_unused_ir;

    assign w_op        = i_ir[31:26];
    assign w_rt        = i_ir[20:16];
    assign w_rd        = i_ir[15:11];
    assign w_funct     = i_ir[5:0];
    // rs goes straight to the register file; shamt has no consumer here
    assign w_unused_ir = ^{i_ir[25:21], i_ir[10:6]};

    always_comb begin
        o_alu_oprn  = ALU_NOP;
        o_rf_wr     = 1'b0;
        o_rf_addr_w = ADDR_BITS'(w_rd);
        o_wb_sel    = WB_SEL_ALU;
        o_mem_rd    = 1'b0;
        o_mem_wr    = 1'b0;
        o_flow      = FLOW_SEQ;
        o_illegal   = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                o_alu_oprn = w_funct;
                if (w_funct == FN_JR) o_flow  = FLOW_JR;
                else                  o_rf_wr = 1'b1;
            end
            OP_ADDI: begin
                o_alu_oprn  = ALU_ADD;
                o_rf_wr     = 1'b1;
                o_rf_addr_w = ADDR_BITS'(w_rt);
            end
            OP_LW: begin
                o_alu_oprn  = ALU_ADD;
                o_rf_wr     = 1'b1;
                o_rf_addr_w = ADDR_BITS'(w_rt);
                o_wb_sel    = WB_SEL_MEM;
                o_mem_rd    = 1'b1;
            end
            OP_SW: begin
                o_alu_oprn = ALU_ADD;
                o_mem_wr   = 1'b1;
            end
            OP_BEQ: begin
                o_alu_oprn = ALU_SUB;
                o_flow     = FLOW_BEQ;
            end
            OP_BNE: begin
                o_alu_oprn = ALU_SUB;
                o_flow     = FLOW_BNE;
            end
            OP_J: o_flow = FLOW_JUMP;
            OP_JAL: begin
                o_flow      = FLOW_JUMP;
                o_rf_wr     = 1'b1;
                o_rf_addr_w = ADDR_BITS'(REG_RA);
                o_wb_sel    = WB_SEL_PC1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// Five-state multi-cycle control sequencer (FETCH, DECODE, EXE, MEM, WB); every instruction takes 5 cycles.
// Outputs are combinational from state and IR and are all forced low while RST is high.
module cu_sequencer
    import proc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] MEM_DATA,
    input  logic                  ZERO,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    output logic [ADDR_BITS-1:0]  RF_ADDR_R1,
    output logic [ADDR_BITS-1:0]  RF_ADDR_R2,
    output logic [ADDR_BITS-1:0]  RF_ADDR_W,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [5:0]            ALU_OPRN,
    output logic [1:0]            WB_SEL,
    output logic                  PC_LOAD,
    output logic [1:0]            PC_SEL,
    output logic [2:0]            STATE,
    output logic                  ILLEGAL
);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_ir;
    logic                  r_taken;
    logic                  r_illegal;

    logic [5:0]            w_alu_oprn;
    logic                  w_rf_wr;
    logic [ADDR_BITS-1:0]  w_rf_addr_w;
    logic [1:0]            w_wb_sel;
    logic                  w_mem_rd;
    logic                  w_mem_wr;
    flow_t                 w_flow;
    logic                  w_illegal;
    logic                  w_taken;

    cu_decode #(.ADDR_BITS(ADDR_BITS)) u_decode (
        .i_ir        (r_ir[31:0]),
        .o_alu_oprn  (w_alu_oprn),
        .o_rf_wr     (w_rf_wr),
        .o_rf_addr_w (w_rf_addr_w),
        .o_wb_sel    (w_wb_sel),
        .o_mem_rd    (w_mem_rd),
        .o_mem_wr    (w_mem_wr),
        .o_flow      (w_flow),
        .o_illegal   (w_illegal)
    );

    assign w_taken = ((w_flow == FLOW_BEQ) &&  ZERO) ||
                     ((w_flow == FLOW_BNE) && !ZERO);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_FETCH)                r_ir      <= MEM_DATA;
            if (r_state == ST_EXE)                  r_taken   <= w_taken;
            if (r_state == ST_DECODE && w_illegal)  r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next     = ST_FETCH;
        RF_READ    = 1'b0;
        RF_WRITE   = 1'b0;
        RF_ADDR_R1 = '0;
        RF_ADDR_R2 = '0;
        RF_ADDR_W  = '0;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        ALU_OPRN   = ALU_NOP;
        WB_SEL     = WB_SEL_ALU;
        PC_LOAD    = 1'b0;
        PC_SEL     = PC_SEL_INC;
        STATE      = 3'd0;
        ILLEGAL    = 1'b0;

        case (r_state)
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: w_next = ST_EXE;
            ST_EXE:    w_next = ST_MEM;
            ST_MEM:    w_next = ST_WB;
            default:   w_next = ST_FETCH;
        endcase

        // Reset masks every output so an abandoned instruction can't strobe anything
        if (!RST) begin
            STATE      = r_state;
            ILLEGAL    = r_illegal;
            RF_ADDR_R1 = ADDR_BITS'(r_ir[25:21]);
            RF_ADDR_R2 = ADDR_BITS'(r_ir[20:16]);
            RF_ADDR_W  = w_rf_addr_w;
            case (r_state)
                ST_FETCH:  MEM_READ = 1'b1;
                ST_DECODE: RF_READ  = 1'b1;
                ST_EXE: begin
                    RF_READ  = 1'b1;
                    ALU_OPRN = w_alu_oprn;
                end
                ST_MEM: begin
                    MEM_READ  = w_mem_rd;
                    MEM_WRITE = w_mem_wr;
                end
                ST_WB: begin
                    PC_LOAD  = 1'b1;
                    RF_WRITE = w_rf_wr;
                    WB_SEL   = w_wb_sel;
                    case (w_flow)
                        FLOW_BEQ, FLOW_BNE: PC_SEL = r_taken ? PC_SEL_BRANCH : PC_SEL_INC;
                        FLOW_JUMP:          PC_SEL = PC_SEL_JUMP;
                        FLOW_JR:            PC_SEL = PC_SEL_RS;
                        default:            PC_SEL = PC_SEL_INC;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: directed instruction scenarios plus random instructions against a rule-level model.
module tb_cu_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] MEM_DATA;
    logic        ZERO;
    logic        RF_READ, RF_WRITE, MEM_READ, MEM_WRITE, PC_LOAD, ILLEGAL;
    logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
    logic [5:0]  ALU_OPRN;
    logic [1:0]  WB_SEL, PC_SEL;
    logic [2:0]  STATE;

    cu_sequencer dut (
        .CLK(CLK), .RST(RST), .MEM_DATA(MEM_DATA), .ZERO(ZERO),
        .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
        .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .ALU_OPRN(ALU_OPRN),
        .WB_SEL(WB_SEL), .PC_LOAD(PC_LOAD), .PC_SEL(PC_SEL),
        .STATE(STATE), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] state;
        logic       rf_read;
        logic       rf_write;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] w;
        logic       mem_read;
        logic       mem_write;
        logic [5:0] alu;
        logic [1:0] wb_sel;
        logic       pc_load;
        logic [1:0] pc_sel;
        logic       illegal;
    } obs_t;

    obs_t cap [5];
    int   n_checks = 0;
    int   n_errors = 0;
    logic m_ill = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o.state = STATE;       o.rf_read = RF_READ;     o.rf_write = RF_WRITE;
        o.r1 = RF_ADDR_R1;     o.r2 = RF_ADDR_R2;       o.w = RF_ADDR_W;
        o.mem_read = MEM_READ; o.mem_write = MEM_WRITE; o.alu = ALU_OPRN;
        o.wb_sel = WB_SEL;     o.pc_load = PC_LOAD;     o.pc_sel = PC_SEL;
        o.illegal = ILLEGAL;
        return o;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
    endfunction

    // Expected outputs in cycle c (0=FETCH .. 4=WB) of instruction w, ZERO=z during EXE
    function automatic obs_t model(input logic [31:0] w, input logic z, input int c, input logic ill_prev);
        obs_t e;
        logic [5:0] op, fn, alu;
        logic [4:0] rs, rt, rd, wa;
        logic wr, mr, mw;
        logic [1:0] wbs, pcs;
        op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; fn = w[5:0];
        wr = 0; mr = 0; mw = 0; alu = 6'h00; wbs = 2'd0; pcs = 2'd0; wa = rd;
        if (op == 6'h00 && fn == 6'h08) begin alu = fn; pcs = 2'd3; end
        else if (op == 6'h00) begin alu = fn; wr = 1; end
        else if (op == 6'h08) begin alu = 6'h20; wr = 1; wa = rt; end
        else if (op == 6'h23) begin alu = 6'h20; wr = 1; wa = rt; mr = 1; wbs = 2'd1; end
        else if (op == 6'h2B) begin alu = 6'h20; mw = 1; end
        else if (op == 6'h04) begin alu = 6'h22; pcs = z ? 2'd1 : 2'd0; end
        else if (op == 6'h05) begin alu = 6'h22; pcs = z ? 2'd0 : 2'd1; end
        else if (op == 6'h02) pcs = 2'd2;
        else if (op == 6'h03) begin pcs = 2'd2; wbs = 2'd2; wr = 1; wa = 5'd31; end
        e = '0;
        e.state     = 3'(c);
        e.rf_read   = (c == 1 || c == 2);
        e.r1        = rs;
        e.r2        = rt;
        e.w         = wa;
        e.mem_read  = (c == 0) || (c == 3 && mr);
        e.mem_write = (c == 3 && mw);
        e.alu       = (c == 2) ? alu : 6'h00;
        e.rf_write  = (c == 4 && wr);
        e.wb_sel    = (c == 4) ? wbs : 2'd0;
        e.pc_sel    = (c == 4) ? pcs : 2'd0;
        e.pc_load   = (c == 4);
        e.illegal   = ill_prev | (!is_legal(op) && c >= 2);
        return e;
    endfunction

    // Blank out don't-care address fields before whole-vector compares
    function automatic obs_t masked(input obs_t o, input int c, input logic care_w);
        if (c == 0) begin o.r1 = '0; o.r2 = '0; end
        if (!care_w) o.w = '0;
        return o;
    endfunction

    // Drives one instruction from FETCH through WB, recording outputs per cycle
    task automatic run_instr(input logic [31:0] w, input logic z);
        MEM_DATA = w;
        ZERO = 1'($urandom_range(0, 1));
        for (int c = 0; c < 5; c++) begin
            if (c == 2) ZERO = z;
            else if (c > 2) ZERO = ~z;
            #1;
            cap[c] = sample();
            @(posedge CLK);
            #1;
            MEM_DATA = $urandom;
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        m_ill = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; MEM_DATA = 32'hFFFF_FFFF; ZERO = 1'b1;
        #3;
        n_checks++;
        if (sample() !== obs_t'(0)) begin n_errors++; $display("FAIL reset_outs got %h exp 0", sample()); end
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (sample() !== obs_t'(0)) begin n_errors++; $display("FAIL reset_held got %h exp 0", sample()); end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++;
        if (STATE !== 3'd0 || MEM_READ !== 1'b1 || RF_READ !== 1'b0) begin
            n_errors++; $display("FAIL reset_release got state=%0d mem_read=%b rf_read=%b exp 0/1/0", STATE, MEM_READ, RF_READ);
        end
    endtask

    task automatic test_add();
        run_instr(32'h0022_1820, 1'b0);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (cap[c].state !== 3'(c)) begin n_errors++; $display("FAIL add_state cyc%0d got %0d exp %0d", c, cap[c].state, c); end
        end
        n_checks++;
        if (cap[1].r1 !== 5'd1 || cap[1].r2 !== 5'd2) begin
            n_errors++; $display("FAIL add_raddr got %0d,%0d exp 1,2", cap[1].r1, cap[1].r2);
        end
        n_checks++;
        if (cap[2].alu !== 6'h20) begin n_errors++; $display("FAIL add_alu got %h exp 20", cap[2].alu); end
        n_checks++;
        if (cap[4].rf_write !== 1'b1 || cap[4].w !== 5'd3 || cap[4].pc_sel !== 2'd0 || cap[4].pc_load !== 1'b1) begin
            n_errors++; $display("FAIL add_wb got wr=%b w=%0d pcsel=%0d pcl=%b exp 1/3/0/1",
                                 cap[4].rf_write, cap[4].w, cap[4].pc_sel, cap[4].pc_load);
        end
    endtask

    task automatic test_mem();
        run_instr(32'h8C25_0004, 1'b0);
        n_checks++;
        if (cap[3].mem_read !== 1'b1 || cap[3].mem_write !== 1'b0) begin
            n_errors++; $display("FAIL lw_mem got rd=%b wr=%b exp 1/0", cap[3].mem_read, cap[3].mem_write);
        end
        n_checks++;
        if (cap[4].rf_write !== 1'b1 || cap[4].w !== 5'd5 || cap[4].wb_sel !== 2'd1) begin
            n_errors++; $display("FAIL lw_wb got wr=%b w=%0d wbsel=%0d exp 1/5/1", cap[4].rf_write, cap[4].w, cap[4].wb_sel);
        end
        run_instr(32'hAC25_0004, 1'b0);
        n_checks++;
        if (cap[3].mem_write !== 1'b1 || cap[3].mem_read !== 1'b0) begin
            n_errors++; $display("FAIL sw_mem got wr=%b rd=%b exp 1/0", cap[3].mem_write, cap[3].mem_read);
        end
        n_checks++;
        if (cap[4].rf_write !== 1'b0) begin n_errors++; $display("FAIL sw_wb got wr=%b exp 0", cap[4].rf_write); end
    endtask

    task automatic test_branch();
        logic [31:0] words [3] = '{32'h1022_0003, 32'h1022_0003, 32'h1422_0003};
        logic        zs    [3] = '{1'b1, 1'b0, 1'b0};
        logic [1:0]  exps  [3] = '{2'd1, 2'd0, 2'd1};
        for (int i = 0; i < 3; i++) begin
            run_instr(words[i], zs[i]);
            n_checks++;
            if (cap[4].pc_sel !== exps[i] || cap[4].rf_write !== 1'b0 || cap[2].alu !== 6'h22) begin
                n_errors++; $display("FAIL branch%0d got pcsel=%0d wr=%b alu=%h exp %0d/0/22",
                                     i, cap[4].pc_sel, cap[4].rf_write, cap[2].alu, exps[i]);
            end
        end
    endtask

    task automatic test_jumps();
        run_instr(32'h0C00_0010, 1'b0);
        n_checks++;
        if (cap[4].w !== 5'd31 || cap[4].wb_sel !== 2'd2 || cap[4].pc_sel !== 2'd2 || cap[4].rf_write !== 1'b1) begin
            n_errors++; $display("FAIL jal_wb got w=%0d wbsel=%0d pcsel=%0d wr=%b exp 31/2/2/1",
                                 cap[4].w, cap[4].wb_sel, cap[4].pc_sel, cap[4].rf_write);
        end
        run_instr(32'h03E0_0008, 1'b1);
        n_checks++;
        if (cap[4].pc_sel !== 2'd3 || cap[4].rf_write !== 1'b0 || cap[1].r1 !== 5'd31) begin
            n_errors++; $display("FAIL jr_wb got pcsel=%0d wr=%b r1=%0d exp 3/0/31", cap[4].pc_sel, cap[4].rf_write, cap[1].r1);
        end
    endtask

    task automatic test_random();
        logic [5:0]  legal_ops [8] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
        logic [31:0] w;
        logic [5:0]  op;
        logic        z;
        obs_t        e;
        for (int i = 0; i < 60; i++) begin
            int k = $urandom_range(0, 8);
            if (k == 8) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                op = legal_ops[k];
            end
            w = $urandom;
            w[31:26] = op;
            if (op == 6'h00 && $urandom_range(0, 3) == 0) w[5:0] = 6'h08;
            z = 1'($urandom_range(0, 1));
            run_instr(w, z);
            for (int c = 0; c < 5; c++) begin
                e = model(w, z, c, m_ill);
                n_checks++;
                if (masked(cap[c], c, e.rf_write) !== masked(e, c, e.rf_write)) begin
                    n_errors++; $display("FAIL rand%0d ir=%h cyc%0d got %h exp %h", i, w, c,
                                         masked(cap[c], c, e.rf_write), masked(e, c, e.rf_write));
                end
            end
            m_ill = m_ill | !is_legal(op);
        end
    endtask

    task automatic test_illegal();
        pulse_reset();
        #1;
        n_checks++;
        if (ILLEGAL !== 1'b0) begin n_errors++; $display("FAIL ill_cleared got %b exp 0", ILLEGAL); end
        run_instr(32'hFC00_0000, 1'b1);
        n_checks++;
        if (cap[4].illegal !== 1'b1 || cap[4].rf_write !== 1'b0 || cap[4].pc_sel !== 2'd0) begin
            n_errors++; $display("FAIL ill_wb got ill=%b wr=%b pcsel=%0d exp 1/0/0", cap[4].illegal, cap[4].rf_write, cap[4].pc_sel);
        end
        run_instr(32'h0022_1820, 1'b0);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (cap[c].illegal !== 1'b1) begin n_errors++; $display("FAIL ill_sticky cyc%0d got %b exp 1", c, cap[c].illegal); end
        end
        pulse_reset();
        #1;
        n_checks++;
        if (ILLEGAL !== 1'b0) begin n_errors++; $display("FAIL ill_reset got %b exp 0", ILLEGAL); end
        run_instr(32'h0022_1820, 1'b0);
        n_checks++;
        if (cap[4].illegal !== 1'b0) begin n_errors++; $display("FAIL ill_after got %b exp 0", cap[4].illegal); end
    endtask

    task automatic test_reset_mid();
        MEM_DATA = 32'hAC25_0004;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (STATE !== 3'd3 || MEM_WRITE !== 1'b1) begin
            n_errors++; $display("FAIL mid_pre got state=%0d memwr=%b exp 3/1", STATE, MEM_WRITE);
        end
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if (MEM_WRITE !== 1'b0 || PC_LOAD !== 1'b0 || RF_WRITE !== 1'b0 || STATE !== 3'd0) begin
            n_errors++; $display("FAIL mid_abort got memwr=%b pcl=%b rfwr=%b state=%0d exp 0/0/0/0",
                                 MEM_WRITE, PC_LOAD, RF_WRITE, STATE);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (sample() !== obs_t'(0)) begin n_errors++; $display("FAIL mid_held got %h exp 0", sample()); end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++;
        if (STATE !== 3'd0 || MEM_READ !== 1'b1) begin
            n_errors++; $display("FAIL mid_release got state=%0d memrd=%b exp 0/1", STATE, MEM_READ);
        end
        run_instr(32'h0022_1820, 1'b0);
        n_checks++;
        if (cap[4].state !== 3'd4 || cap[4].rf_write !== 1'b1 || cap[4].w !== 5'd3) begin
            n_errors++; $display("FAIL mid_resume got state=%0d wr=%b w=%0d exp 4/1/3", cap[4].state, cap[4].rf_write, cap[4].w);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_mem();
        test_branch();
        test_jumps();
        test_random();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
